// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the data-memory responder:
//   - access size encodings (SIZE_B / SIZE_H / SIZE_W, 2'b11 illegal)
//   - responder FSM state encodings (ST_IDLE / ST_WAIT / ST_RESP)
//   - dmem_req_t: one captured core request
//   - helpers for byte-lane enables, store-data lane replication and
//     load extraction/extension
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [1:0] SIZE_B       = 2'b00;
    localparam logic [1:0] SIZE_H       = 2'b01;
    localparam logic [1:0] SIZE_W       = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } dmem_req_t;

    // Lanes touched by an access. Half ignores addr[0] and word ignores
    // addr[1:0]; alignment faults are decided elsewhere.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; replicate it so that whichever
    // lane is enabled sees the right bits.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_B:  d = {4{wdata[7:0]}};
            SIZE_H:  d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic [1:0]  addr_lo,
                                                input logic        is_unsigned,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {addr_lo, 3'b000};
        b       = shifted[7:0];
        h       = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_H:  r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            SIZE_W:  r = word;
            default: r = 32'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// DEPTH_WORDS x 32-bit storage with per-byte write enables, synchronous
// write and a registered read port.
// Ports:
//   clk    - clock, all activity on the rising edge
//   we     - write strobe; lanes selected by be
//   be     - 4-bit byte-lane enable (bit i writes wdata[8i+7:8i])
//   addr   - word index
//   wdata  - write data (already lane-replicated)
//   re     - read strobe; rdata updates on the next edge, holds otherwise
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:DEPTH_WORDS-1];
    logic [31:0] rdata_q;

    // NOTE: storage and its read register have no reset; contents must
    // survive a reset, and an unreset array maps onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory slave for an RV32 core. A request is
// accepted in IDLE, optionally delayed WAIT_CYCLES cycles in WAIT, committed
// to storage on the edge that enters RESP, and its response held in RESP
// until the core takes it.
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words (power of two)
//   WAIT_CYCLES - extra cycles between accept and commit (0..15)
// Ports:
//   clk, reset           - clock; asynchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only in IDLE)
//   req_addr             - byte address
//   req_write            - 1 store, 0 load
//   req_size             - 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned         - load zero-extends when 1
//   req_wdata            - right-aligned store data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - extended load data; 0 for stores and faults
//   rsp_err              - access faulted, memory untouched
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  - when defined, misaligned half/word accesses fault;
//                          otherwise the misaligned low address bits are
//                          ignored.
// -----------------------------------------------------------------------------
module dmem_responder
    import rv32_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    dmem_req_t  req_q,   req_d;
    logic       err_q,   err_d;

    dmem_req_t   req_in;
    dmem_req_t   cur;
    logic        accept;
    logic        commit;
    logic        cur_err;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic        ram_re;

    assign req_in = '{addr:        req_addr,
                      write:       req_write,
                      size:        req_size,
                      is_unsigned: req_unsigned,
                      wdata:       req_wdata};

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid & req_ready;

    // With WAIT_CYCLES=0 the commit happens on the accept edge itself, so the
    // access must come straight from the ports rather than the capture regs.
    assign cur = (state_q == ST_IDLE) ? req_in : req_q;

    always_comb begin
        cur_err = 1'b0;
        if (cur.size == SIZE_ILLEGAL) begin
            cur_err = 1'b1;
        end
        if ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            cur_err = 1'b1;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        if (cur.size == SIZE_H && cur.addr[0]) begin
            cur_err = 1'b1;
        end
        if (cur.size == SIZE_W && cur.addr[1:0] != 2'b00) begin
            cur_err = 1'b1;
        end
`endif
    end

    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d = req_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // Counter holds the cycles still to spend in WAIT, this one
                // included; the last one commits.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (commit) begin
            err_d = cur_err;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // Reset is combinationally folded in because storage ignores it: a
    // request offered while reset is held must not reach memory.
    assign ram_we = commit & ~reset & cur.write & ~cur_err;
    assign ram_re = commit & ~cur.write;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (byte_enable(cur.size, cur.addr[1:0])),
        .addr  (cur.addr[AW+1:2]),
        .wdata (lane_wdata(cur.size, cur.wdata)),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // The RAM read register only moves on a commit, so everything below is
    // stable for the whole RESP stay.
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !req_q.write)
                     ? load_extend(req_q.size, req_q.addr[1:0], req_q.is_unsigned, ram_rdata)
                     : 32'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Drives directed and random requests into dmem_responder and compares each
// response against a byte-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 2048;
    localparam int WAITC = 1;
    localparam int MEM_BYTES = DEPTH * 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp;
    int n_bad;

    logic [7:0] mem_m [0:MEM_BYTES-1];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Reference: memory is a flat byte array, little-endian. An access of
    // n bytes covers the n bytes starting at addr rounded down to n.
    function automatic void ref_access(input logic [31:0] a, input logic w,
                                       input logic [1:0] s, input logic u,
                                       input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
        int          nbytes;
        int          base;
        logic [31:0] val;
        rd     = 32'b0;
        er     = 1'b0;
        nbytes = 1;
        if (s == 2'b11) begin
            er = 1'b1;
        end else begin
            nbytes = 1 << s;
            if ((a / 4) >= DEPTH) er = 1'b1;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        if (!er && (a % nbytes) != 0) er = 1'b1;
`endif
        if (!er) begin
            base = int'(a) - int'(a % nbytes);
            if (w) begin
                for (int i = 0; i < nbytes; i++) mem_m[base + i] = wd[8*i +: 8];
            end else begin
                val = 32'b0;
                for (int i = 0; i < nbytes; i++) val = val | (32'(mem_m[base + i]) << (8 * i));
                if (!u && nbytes < 4 && val[8*nbytes-1]) val = val - (32'd1 << (8 * nbytes));
                rd = val;
            end
        end
    endfunction

    // One complete transaction; the response is held off for 'hold' cycles.
    task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] wd, input int hold);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat;
        ref_access(a, w, s, u, wd, exp_rd, exp_er);
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = a;
        req_write    = w;
        req_size     = s;
        req_unsigned = u;
        req_wdata    = wd;
        rsp_ready    = 1'b0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        check("latency", 32'(lat), 32'(WAITC + 1));
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(exp_er));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_er));
        check("resp_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 32'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'b0;
        rsp_ready    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_valid_after", 32'(rsp_valid), 32'd0);

        // Known contents for the random region and the far word.
        for (int i = 0; i < 64; i++) xact(32'(i * 4), 1'b1, 2'b10, 1'b0, $urandom, 0);
        xact(32'h1000, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 0);

        // Word store/load round trip.
        xact(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
        xact(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 0);

        // Byte store into a cleared word, signed byte and unsigned word loads.
        xact(32'h10, 1'b1, 2'b10, 1'b0, 32'h0, 0);
        xact(32'h13, 1'b1, 2'b00, 1'b0, 32'h0000_0080, 0);
        xact(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 0);
        xact(32'h10, 1'b0, 2'b10, 1'b1, 32'h0, 0);

        // Upper-half store leaves lanes 1..0 intact.
        xact(32'h22, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 0);
        xact(32'h22, 1'b0, 2'b01, 1'b1, 32'h0, 0);
        xact(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, 0);

        // Back-pressure for five cycles.
        xact(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 5);

        // Misaligned word, illegal size, out-of-range store and load.
        xact(32'h1002, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        xact(32'h30, 1'b0, 2'b11, 1'b0, 32'h0, 0);
        xact(32'h30, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFF, 0);
        xact(32'h30, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        xact(32'h2000, 1'b1, 2'b10, 1'b0, 32'h1111_1111, 0);
        xact(32'h2000, 1'b0, 2'b10, 1'b0, 32'h0, 1);

        // Reset while a store sits in WAIT: the store must vanish.
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = 32'h40;
        req_write    = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("midwait_rst_valid", 32'(rsp_valid), 32'd0);
        check("midwait_rst_rdata", rsp_rdata, 32'd0);
        check("midwait_rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midwait_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midwait_no_rsp", 32'(rsp_valid), 32'd0);
        end
        xact(32'h40, 1'b0, 2'b00, 1'b1, 32'h0, 0);
        xact(32'h40, 1'b0, 2'b10, 1'b0, 32'h0, 0);

        // Random traffic inside the initialised region plus faulting accesses.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_2000;
            else                          a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) s = 2'b11;
            else                           s = 2'($urandom_range(0, 2));
            xact(a, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
                 $urandom, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
